uart_tx_stage: RTL and testbench

UART_TX_STAGE -- requirements
Module: uart_tx_stage

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_stage.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit stage.
// Build option: UART_TX_PARITY_EN adds the even-parity state to the frame.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // Level of the serial line between frames (also the stop-bit level)
  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Clock cycles per serial bit; integer division truncates
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous byte FIFO with occupancy count and full/empty
// flags. A push while full is accepted only when a pop happens on the same
// edge; otherwise the byte is dropped and stored entries are untouched.
// Read data is first-word fall-through: rd_data_o shows the head entry.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pop       = rd_en_i && !empty_o;
  assign push      = wr_en_i && (!full_o || pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_stage.sv
// UART transmit stage: buffers bytes from the SDRAM read path and sends
// them as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first.
// Frames chain with no idle bit while the buffer holds data.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned BUSY_MARGIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       busy,
  output logic       tx,
  output logic       tx_idle
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] BUSY_THRESH = (AW+1)'(FIFO_DEPTH - BUSY_MARGIN);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q;
  logic          baud_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rd_data;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // A full buffer still takes a byte on an edge where the FSM pops one
  assign fifo_push = din_vld && (!fifo_full || fifo_pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (fifo_push),
    .wr_data_i (din),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next-state, bit timing, shifter and registered line level
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    baud_done  = (baud_cnt_q == CNT_LAST);

    if (state_q != ST_IDLE) begin
      baud_cnt_d = baud_done ? '0 : baud_cnt_q + CW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        tx_d = TX_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_rd_data;
`endif
          tx_d     = ~TX_IDLE_LEVEL;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d      = parity_q;
            state_d   = ST_PARITY;
`else
            tx_d      = TX_IDLE_LEVEL;
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          tx_d    = TX_IDLE_LEVEL;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
            tx_d     = ~TX_IDLE_LEVEL;
            state_d  = ST_START;
          end else begin
            tx_d    = TX_IDLE_LEVEL;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        tx_d    = TX_IDLE_LEVEL;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame registers, line flop and registered busy (one cycle behind count)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= TX_IDLE_LEVEL;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= (fifo_count >= BUSY_THRESH);
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_idle = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage; honours UART_TX_PARITY_EN for frame length.
module tb_uart_tx_stage;

  localparam int unsigned T_CLK_FREQ = 1_000_000;
  localparam int unsigned T_BAUD     = 100_000;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic       busy;
  logic       tx;
  logic       tx_idle;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  uart_tx_stage #(
    .CLK_FREQ    (T_CLK_FREQ),
    .BAUD        (T_BAUD),
    .FIFO_DEPTH  (16),
    .BUSY_MARGIN (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .busy    (busy),
    .tx      (tx),
    .tx_idle (tx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    din = b; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  // Waits (bounded) for a start bit, then samples every cycle of the frame;
  // ok drops if any bit level changes inside its period or framing is wrong.
  task automatic recv(input int budget, output logic found, output logic ok,
                      output logic [7:0] data, output logic par, output int st);
    logic [NB-1:0] bits;
    logic first;
    found = 1'b0; ok = 1'b1; data = '0; par = 1'b0; st = 0; bits = '0;
    for (int n = 0; n < budget; n++) begin
      if (tx === 1'b0) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!found) return;
    st = cyc;
    for (int k = 0; k < NB; k++) begin
      first = tx;
      bits[k] = tx;
      for (int j = 0; j < DIV; j++) begin
        if (tx !== first) ok = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) ok = 1'b0;
    data = bits[8:1];
`ifdef UART_TX_PARITY_EN
    par = bits[9];
`endif
  endtask

  task automatic test_reset();
    int low;
    rst_n = 1'b0; din = 8'hAA; din_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b expected 1", tx_idle); end
    checks++; if (dut.fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.fifo_count); end
    din_vld = 1'b0; rst_n = 1'b1;
    low = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) low++;
    end
    checks++; if (low !== 0) begin errors++; $display("FAIL post_reset_quiet: got %0d low cycles expected 0", low); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b expected 1", tx_idle); end
  endtask

  task automatic test_baud_div();
    int unsigned d;
    d = uart_pkg::baud_div(100_000_000, 115200);
    checks++; if (d !== 32'd868) begin errors++; $display("FAIL baud_div_default: got %0d expected 868", d); end
    d = uart_pkg::baud_div(T_CLK_FREQ, T_BAUD);
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL baud_div_bench: got %0d expected 10", d); end
  endtask

  task automatic test_single();
    logic f, ok, p; logic [7:0] d; int st, n0;
    push_byte(8'h55);
    n0 = cyc;
    checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL single_idle_drop: got %b expected 0", tx_idle); end
    recv(4 * DIV, f, ok, d, p, st);
    checks++; if (f !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL single_frame: got found=%b ok=%b expected 1 1", f, ok); end
    checks++; if (st !== n0 + 1) begin errors++; $display("FAIL single_latency: got start %0d expected %0d", st, n0 + 1); end
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", d); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b expected 1", tx_idle); end
  endtask

  task automatic test_burst();
    logic fnd[16]; logic okv[16]; logic [7:0] dat[16]; logic par[16]; int st[16];
    int n0;
    n0 = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          din = 8'(i); din_vld = 1'b1;
          @(posedge clk); #1;
          if (i == 0) n0 = cyc;
          if (i == 12) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_low: got %b expected 0", busy); end
          end
          if (i == 13) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy_high: got %b expected 1", busy); end
          end
        end
        din_vld = 1'b0;
      end
      begin
        for (int k = 0; k < 16; k++) recv(4 * DIV, fnd[k], okv[k], dat[k], par[k], st[k]);
      end
    join
    for (int k = 0; k < 16; k++) begin
      checks++; if (fnd[k] !== 1'b1 || okv[k] !== 1'b1) begin errors++; $display("FAIL burst_frame[%0d]: got found=%b ok=%b expected 1 1", k, fnd[k], okv[k]); end
      checks++; if (dat[k] !== 8'(k)) begin errors++; $display("FAIL burst_data[%0d]: got %h expected %h", k, dat[k], 8'(k)); end
      checks++; if (st[k] !== n0 + 1 + k * FRAME) begin errors++; $display("FAIL burst_start[%0d]: got %0d expected %0d", k, st[k], n0 + 1 + k * FRAME); end
    end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL burst_idle_after: got %b expected 1", tx_idle); end
  endtask

  task automatic test_drain17();
    logic fnd[17]; logic okv[17]; logic [7:0] dat[17]; logic par[17]; int st[17];
    int n0;
    n0 = 0;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          din = 8'hA0 + 8'(i); din_vld = 1'b1;
          @(posedge clk); #1;
          if (i == 0) n0 = cyc;
        end
        din_vld = 1'b0;
      end
      begin
        for (int k = 0; k < 17; k++) recv(4 * DIV, fnd[k], okv[k], dat[k], par[k], st[k]);
      end
    join
    for (int k = 0; k < 17; k++) begin
      checks++; if (fnd[k] !== 1'b1 || okv[k] !== 1'b1 || dat[k] !== 8'hA0 + 8'(k)) begin
        errors++; $display("FAIL drain17[%0d]: got found=%b ok=%b data=%h expected 1 1 %h", k, fnd[k], okv[k], dat[k], 8'hA0 + 8'(k));
      end
      checks++; if (st[k] !== n0 + 1 + k * FRAME) begin errors++; $display("FAIL drain17_start[%0d]: got %0d expected %0d", k, st[k], n0 + 1 + k * FRAME); end
    end
  endtask

  task automatic test_full();
    logic fnd[18]; logic okv[18]; logic [7:0] dat[18]; logic par[18]; int st[18];
    logic [7:0] exp_d[18];
    logic f, ok, p; logic [7:0] d; int s;
    int n0;
    n0 = 0;
    exp_d[0] = 8'h5A;
    for (int i = 0; i < 16; i++) exp_d[i + 1] = 8'hC0 + 8'(i);
    exp_d[17] = 8'h99;
    fork
      begin
        push_byte(8'h5A);
        n0 = cyc;
        for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i));
        checks++; if (dut.fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", dut.fifo_count); end
        push_byte(8'hEE);
        checks++; if (dut.fifo_count !== 5'd16) begin errors++; $display("FAIL full_drop_count: got %0d expected 16", dut.fifo_count); end
        wait_until(n0 + FRAME);
        push_byte(8'h99);
        checks++; if (dut.fifo_count !== 5'd16) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 16", dut.fifo_count); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL full_pushpop_start: got %b expected 0", tx); end
      end
      begin
        for (int k = 0; k < 18; k++) recv(4 * DIV, fnd[k], okv[k], dat[k], par[k], st[k]);
      end
    join
    for (int k = 0; k < 18; k++) begin
      checks++; if (fnd[k] !== 1'b1 || okv[k] !== 1'b1 || dat[k] !== exp_d[k]) begin
        errors++; $display("FAIL full_seq[%0d]: got found=%b ok=%b data=%h expected 1 1 %h", k, fnd[k], okv[k], dat[k], exp_d[k]);
      end
      checks++; if (st[k] !== n0 + 1 + k * FRAME) begin errors++; $display("FAIL full_start[%0d]: got %0d expected %0d", k, st[k], n0 + 1 + k * FRAME); end
    end
    recv(2 * FRAME, f, ok, d, p, s);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL full_no_extra: got found=%b data=%h expected no frame", f, d); end
  endtask

  task automatic test_reset_midframe();
    logic f, ok, p; logic [7:0] d; int st, n0, low;
    n0 = 0;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'hF0 + 8'(i));
      if (i == 0) n0 = cyc;
    end
    wait_until(n0 + 1 + 4 * DIV + 3);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3: got %b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_tx_async: got %b expected 1", tx); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL midframe_idle: got %b expected 1", tx_idle); end
    checks++; if (dut.fifo_count !== 5'd0) begin errors++; $display("FAIL midframe_flush: got %0d expected 0", dut.fifo_count); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    low = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) low++;
    end
    checks++; if (low !== 0) begin errors++; $display("FAIL midframe_quiet: got %0d low cycles expected 0", low); end
    push_byte(8'h3C);
    n0 = cyc;
    recv(4 * DIV, f, ok, d, p, st);
    checks++; if (f !== 1'b1 || ok !== 1'b1 || d !== 8'h3C) begin
      errors++; $display("FAIL midframe_recover: got found=%b ok=%b data=%h expected 1 1 3c", f, ok, d);
    end
    checks++; if (st !== n0 + 1) begin errors++; $display("FAIL midframe_recover_latency: got %0d expected %0d", st, n0 + 1); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic f, ok, p; logic [7:0] d; int st;
    push_byte(8'h07);
    recv(4 * DIV, f, ok, d, p, st);
    checks++; if (f !== 1'b1 || ok !== 1'b1 || d !== 8'h07) begin errors++; $display("FAIL parity07_frame: got found=%b ok=%b data=%h expected 1 1 07", f, ok, d); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL parity07_bit: got %b expected 1", p); end
    push_byte(8'h03);
    recv(4 * DIV, f, ok, d, p, st);
    checks++; if (f !== 1'b1 || ok !== 1'b1 || d !== 8'h03) begin errors++; $display("FAIL parity03_frame: got found=%b ok=%b data=%h expected 1 1 03", f, ok, d); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL parity03_bit: got %b expected 0", p); end
  endtask
`endif

  initial begin
    test_reset();
    test_baud_div();
    test_single();
    test_burst();
    test_drain17();
    test_full();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
